// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared FSM state, sizing helper and index type for the instruction fetch sequencer
package ifetch_pkg;
  localparam int DATA_W = 32;
  localparam int LINE_WORDS = 4;
  typedef enum logic {RUN, FILL} state_e;
  typedef logic [$clog2(LINE_WORDS)-1:0] widx_t;
  function automatic int off_w(input int line_words);
    return $clog2(line_words * 4);
  endfunction
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: word-at-a-time memory read handshake between fetch sequencer (master) and memory (slave)
interface ifetch_if import ifetch_pkg::*; #(parameter int dataW = DATA_W) ();
  logic MemReq, MemAck;
  logic [dataW-1:0] MemAddr, MemData;
  modport master (output MemReq, MemAddr, input MemAck, MemData);
  modport slave (input MemReq, MemAddr, output MemAck, MemData);
endinterface

// File: rtl/ifetch_line_buf.sv
// ifetch_line_buf: single-line instruction storage with tag/valid, hit compare and word read mux
module ifetch_line_buf import ifetch_pkg::*; #(
  parameter int dataW = DATA_W,
  parameter int lineWords = LINE_WORDS,
  parameter int idxW = off_w(lineWords) - 2,
  parameter int tagW = dataW - off_w(lineWords)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             tag_we_i,
  input  logic [tagW-1:0]  tag_i,
  input  logic [idxW-1:0]  rd_idx_i,
  input  logic             wr_en_i,
  input  logic [idxW-1:0]  wr_idx_i,
  input  logic [dataW-1:0] wr_data_i,
  input  logic             valid_we_i,
  input  logic             valid_i,
  output logic             hit_o,
  output logic [dataW-1:0] rd_data_o,
  output logic [tagW-1:0]  tag_o
);
  logic [dataW-1:0] words_q [lineWords];
  logic [tagW-1:0] tag_q;
  logic valid_q;
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else if (valid_we_i) valid_q <= valid_i;
    if (tag_we_i) tag_q <= tag_i;
    if (wr_en_i) words_q[wr_idx_i] <= wr_data_i;
  end
  assign hit_o = run_i && valid_q && tag_q == tag_i;
  assign rd_data_o = hit_o ? words_q[rd_idx_i] : '0;
  assign tag_o = tag_q;
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: stalls the PC on a line miss and refills the line over the memory req/ack handshake
// IFETCH_WRAP_FILL_EN selects critical-word-first fill order.
module ifetch_ctrl import ifetch_pkg::*; #(
  parameter int dataW = DATA_W,
  parameter int lineWords = LINE_WORDS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             Flush,
  output logic             InsCacheStall,
  output logic [dataW-1:0] Instruction,
  output logic             InsValid,
  ifetch_if.master         mem
);
  localparam int offW = off_w(lineWords);
  localparam int idxW = offW - 2;
  localparam int tagW = dataW - offW;
  state_e state_q, state_d;
  logic [idxW-1:0] fill_idx_q, fill_idx_d, fill_idx_nx, fill_cnt_q, fill_cnt_d, word_idx, start_idx;
  logic [tagW-1:0] tag, line_tag;
  logic [dataW-1:0] addr_q, addr_d;
  logic flush_pend_q, flush_pend_d, req_q, req_d;
  logic hit, start, ack, last, unused_pa;
  assign tag = ProgAddr[dataW-1:offW];
  assign word_idx = ProgAddr[offW-1:2];
  assign unused_pa = ^ProgAddr[1:0];
`ifdef IFETCH_WRAP_FILL_EN
  assign start_idx = word_idx;
`else
  assign start_idx = '0;
`endif
  assign start = state_q == RUN && !hit && !Flush;
  assign ack = state_q == FILL && mem.MemAck;
  assign last = ack && fill_cnt_q == idxW'(lineWords - 1);
  assign fill_idx_nx = fill_idx_q + 1'b1;
  always_comb begin
    state_d = state_q;
    fill_idx_d = fill_idx_q;
    fill_cnt_d = fill_cnt_q;
    flush_pend_d = flush_pend_q;
    req_d = req_q;
    addr_d = addr_q;
    if (start) begin
      state_d = FILL;
      fill_idx_d = start_idx;
      fill_cnt_d = '0;
      flush_pend_d = 1'b0;
      req_d = 1'b1;
      addr_d = {tag, start_idx, 2'b00};
    end
    if (state_q == FILL) begin
      flush_pend_d = flush_pend_q | Flush;
      if (mem.MemAck) begin
        fill_idx_d = fill_idx_nx;
        fill_cnt_d = fill_cnt_q + 1'b1;
        addr_d = {line_tag, fill_idx_nx, 2'b00};
      end
      if (last) begin
        req_d = 1'b0;
        state_d = RUN;
        flush_pend_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      fill_idx_q <= '0;
      fill_cnt_q <= '0;
      flush_pend_q <= 1'b0;
      req_q <= 1'b0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      fill_idx_q <= fill_idx_d;
      fill_cnt_q <= fill_cnt_d;
      flush_pend_q <= flush_pend_d;
      req_q <= req_d;
      addr_q <= addr_d;
    end
  end
  // a flush arriving on the final ack still leaves the new line invalid
  ifetch_line_buf #(.dataW(dataW), .lineWords(lineWords)) u_buf (
    .clk(clock), .rst(reset), .run_i(state_q == RUN), .tag_we_i(start), .tag_i(tag),
    .rd_idx_i(word_idx), .wr_en_i(ack), .wr_idx_i(fill_idx_q), .wr_data_i(mem.MemData),
    .valid_we_i((state_q == RUN && Flush) || last), .valid_i(last && !flush_pend_q && !Flush),
    .hit_o(hit), .rd_data_o(Instruction), .tag_o(line_tag)
  );
  assign InsValid = hit;
  assign InsCacheStall = !hit;
  assign mem.MemReq = req_q;
  assign mem.MemAddr = addr_q;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed plus randomized checks of ifetch_ctrl against a line-level reference model
module tb_ifetch_ctrl;
  localparam int LW = 4;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ack = 1'b0;
  logic [31:0] pa = 32'h0;
  logic stall, ival;
  logic [31:0] ins;
  int checks = 0, errors = 0;
  bit m_fill, m_valid, m_pend;
  logic [27:0] m_tag;
  logic [31:0] m_q[$];
  logic [31:0] lines[4] = '{32'h10, 32'h20, 32'h30, 32'hFFFF_FFF0};

  ifetch_if #(.dataW(32)) mem_bus ();
  ifetch_ctrl #(.dataW(32), .lineWords(LW)) dut (
    .clock(clk), .reset(rst), .ProgAddr(pa), .Flush(flush), .InsCacheStall(stall),
    .Instruction(ins), .InsValid(ival), .mem(mem_bus)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w[31:4] == 28'h1) ? 32'hA0 + {28'h0, w[3:2]} : (w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction
  assign mem_bus.MemData = memf(mem_bus.MemAddr);
  assign mem_bus.MemAck = ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // compare outputs for the current inputs, then advance the model across one clock edge
  task automatic step();
    bit hit;
    logic [1:0] first, wi;
    @(negedge clk);
    hit = !m_fill && m_valid && m_tag == pa[31:4];
    check("InsValid", 32'(ival), 32'(hit));
    check("InsCacheStall", 32'(stall), 32'(!hit));
    check("Instruction", ins, hit ? memf(pa) : 32'h0);
    check("MemReq", 32'(mem_bus.MemReq), 32'(m_fill));
    if (m_fill) check("MemAddr", mem_bus.MemAddr, m_q[0]);
    if (rst) begin
      m_fill = 0; m_valid = 0; m_pend = 0; m_q.delete();
    end else if (!m_fill) begin
      if (flush) m_valid = 0;
      else if (!hit) begin
        m_fill = 1; m_pend = 0; m_tag = pa[31:4];
`ifdef IFETCH_WRAP_FILL_EN
        first = pa[3:2];
`else
        first = 2'd0;
`endif
        for (int k = 0; k < LW; k++) begin
          wi = first + 2'(k);
          m_q.push_back({pa[31:4], wi, 2'b00});
        end
      end
    end else begin
      if (flush) m_pend = 1;
      if (ack) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_fill = 0;
          m_valid = !m_pend;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; ack = 1;
    @(posedge clk); #1;
    m_fill = 0; m_valid = 0; m_pend = 0;
    step();
    rst = 0; pa = 32'h10;
    check("rst_MemAddr", mem_bus.MemAddr, 32'h0);
    check("rst_MemReq", 32'(mem_bus.MemReq), 32'h0);
    check("rst_stall", 32'(stall), 32'h1);
    repeat (5) step();
    for (int i = 0; i < 4; i++) begin pa = 32'h10 + 32'(i * 4); step(); end
    check("line10_word3", ins, 32'hA3);
    pa = 32'h20; repeat (6) step();
    pa = 32'h14; repeat (6) step();
    check("line10_refill", ins, 32'hA1);
    pa = 32'h30;
    for (int i = 0; i < 10; i++) begin ack = (i % 2 == 0); step(); end
    ack = 1; pa = 32'h34; step();
    pa = 32'h40; step(); step();
    flush = 1; step();
    flush = 0; repeat (12) step();
    pa = 32'h50; repeat (3) step();
    rst = 1; step();
    rst = 0;
    check("midfill_rst_req", 32'(mem_bus.MemReq), 32'h0);
    check("midfill_rst_valid", 32'(ival), 32'h0);
    pa = 32'h10; repeat (6) step();
    flush = 1; step();
    flush = 0; pa = 32'h18; repeat (6) step();
    for (int i = 0; i < 4; i++) begin pa = 32'h10 + 32'(i * 4); step(); end
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(99) == 0);
      flush = ($urandom_range(19) == 0);
      ack = 1'($urandom_range(1));
      if ($urandom_range(2) == 0) pa = lines[$urandom_range(3)] + 32'($urandom_range(3) * 4) + 32'($urandom_range(3));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
